// File: rtl/mips_pkg.sv
// Shared encodings for the single-cycle MIPS-subset core: field widths,
// opcode/funct values and the ALU operation set.
package mips_pkg;

    localparam int OP_W    = 6;
    localparam int REG_W   = 5;
    localparam int SHAMT_W = 5;
    localparam int FUNCT_W = 6;
    localparam int IMM_W   = 16;
    localparam int TGT_W   = 26;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_ADDIU = 6'h09;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
    localparam logic [OP_W-1:0] OP_SLTIU = 6'h0B;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    localparam logic [FUNCT_W-1:0] F_SLL  = 6'h00;
    localparam logic [FUNCT_W-1:0] F_SRL  = 6'h02;
    localparam logic [FUNCT_W-1:0] F_JR   = 6'h08;
    localparam logic [FUNCT_W-1:0] F_ADD  = 6'h20;
    localparam logic [FUNCT_W-1:0] F_ADDU = 6'h21;
    localparam logic [FUNCT_W-1:0] F_SUB  = 6'h22;
    localparam logic [FUNCT_W-1:0] F_SUBU = 6'h23;
    localparam logic [FUNCT_W-1:0] F_AND  = 6'h24;
    localparam logic [FUNCT_W-1:0] F_OR   = 6'h25;
    localparam logic [FUNCT_W-1:0] F_NOR  = 6'h27;
    localparam logic [FUNCT_W-1:0] F_SLT  = 6'h2A;
    localparam logic [FUNCT_W-1:0] F_SLTU = 6'h2B;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_NOR,
        ALU_SLT,
        ALU_SLTU,
        ALU_SLL,
        ALU_SRL,
        ALU_LUI
    } alu_op_e;

    function automatic logic [31:0] sext16(input logic [IMM_W-1:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/mips_data_mem.sv
// Data memory, word addressed: combinational read, synchronous write.
// Addresses wrap modulo the memory depth.
module mips_data_mem #(
    parameter int DMEM_WORDS = 256
) (
    input  logic        clock,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o
);

    localparam int AW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

    logic [31:0] data_mem [0:DMEM_WORDS-1];
    logic [AW-1:0] idx;

    assign idx     = AW'(addr_i % 32'(DMEM_WORDS));
    assign rdata_o = data_mem[idx];

    // Store path: one word per edge when enabled.
    always_ff @(posedge clock) begin
        if (we_i) begin
            data_mem[idx] <= wdata_i;
        end
    end

endmodule

// File: rtl/mips_instr_mem.sv
// Instruction memory, word addressed, combinational read. Contents are
// loaded from outside; nothing in the design writes it.
module mips_instr_mem #(
    parameter int IMEM_WORDS = 256
) (
    input  logic [31:0] addr_i,
    output logic [31:0] instr_o
);

    localparam int AW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;

    logic [31:0] instr_mem [0:IMEM_WORDS-1];
    logic [AW-1:0] idx;

    assign idx     = AW'(addr_i % 32'(IMEM_WORDS));
    assign instr_o = instr_mem[idx];

endmodule

// File: rtl/mips_regfile.sv
// 32x32 register file: two combinational read ports, one write port.
// Register 0 reads as zero and ignores writes.
module mips_regfile
    import mips_pkg::*;
(
    input  logic             clock,
    input  logic             we_i,
    input  logic [REG_W-1:0] waddr_i,
    input  logic [31:0]      wdata_i,
    input  logic [REG_W-1:0] raddr_a_i,
    input  logic [REG_W-1:0] raddr_b_i,
    output logic [31:0]      rdata_a_o,
    output logic [31:0]      rdata_b_o
);

    logic [31:0] registers [0:31];

    assign rdata_a_o = (raddr_a_i == '0) ? 32'd0 : registers[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == '0) ? 32'd0 : registers[raddr_b_i];

    // Single write per edge; writes aimed at register 0 are dropped.
    always_ff @(posedge clock) begin
        if (we_i && (waddr_i != '0)) begin
            registers[waddr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/mips_sc_core.sv
// Single-cycle MIPS-subset core. Decode, ALU and next-PC selection are
// combinational; the only state here is the PC.
module mips_sc_core
    import mips_pkg::*;
#(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_WORDS = 256
) (
    input  logic clock,
    input  logic reset
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr, pc_plus1, br_target;
    logic [OP_W-1:0]    op;
    logic [REG_W-1:0]   rs, rt, rd;
    logic [SHAMT_W-1:0] shamt;
    logic [FUNCT_W-1:0] funct;
    logic [IMM_W-1:0]   imm;
    logic [TGT_W-1:0]   target;
    logic [31:0] rs_val, rt_val, alu_b, alu_y, mem_rdata, wb_data;
    alu_op_e     alu_op;
    logic        use_imm, zext_imm, reg_we, mem_we, mem_to_reg, link;
    logic [REG_W-1:0] wr_addr;

    assign op     = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign shamt  = instr[10:6];
    assign funct  = instr[5:0];
    assign imm    = instr[15:0];
    assign target = instr[25:0];

    assign pc_plus1  = pc_q + 32'd1;
    assign br_target = pc_plus1 + sext16(imm);

    mips_instr_mem #(.IMEM_WORDS(IMEM_WORDS)) Instruction_memory (
        .addr_i  (pc_q),
        .instr_o (instr)
    );

    mips_regfile Registers (
        .clock     (clock),
        .we_i      (reg_we && !reset),
        .waddr_i   (wr_addr),
        .wdata_i   (wb_data),
        .raddr_a_i (rs),
        .raddr_b_i (rt),
        .rdata_a_o (rs_val),
        .rdata_b_o (rt_val)
    );

    mips_data_mem #(.DMEM_WORDS(DMEM_WORDS)) Data_memory (
        .clock   (clock),
        .we_i    (mem_we && !reset),
        .addr_i  (alu_y),
        .wdata_i (rt_val),
        .rdata_o (mem_rdata)
    );

    // Decode: select ALU op, operand source, write targets and next PC.
    always_comb begin
        alu_op     = ALU_ADD;
        use_imm    = 1'b0;
        zext_imm   = 1'b0;
        reg_we     = 1'b0;
        mem_we     = 1'b0;
        mem_to_reg = 1'b0;
        link       = 1'b0;
        wr_addr    = rt;
        pc_d       = pc_plus1;
        case (op)
            OP_RTYPE: begin
                wr_addr = rd;
                reg_we  = 1'b1;
                case (funct)
                    F_ADD, F_ADDU: alu_op = ALU_ADD;
                    F_SUB, F_SUBU: alu_op = ALU_SUB;
                    F_AND:         alu_op = ALU_AND;
                    F_OR:          alu_op = ALU_OR;
                    F_NOR:         alu_op = ALU_NOR;
                    F_SLT:         alu_op = ALU_SLT;
                    F_SLTU:        alu_op = ALU_SLTU;
                    F_SLL:         alu_op = ALU_SLL;
                    F_SRL:         alu_op = ALU_SRL;
                    F_JR: begin
                        reg_we = 1'b0;
                        pc_d   = rs_val;
                    end
                    default:       reg_we = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin use_imm = 1'b1; reg_we = 1'b1; end
            OP_SLTI:  begin use_imm = 1'b1; reg_we = 1'b1; alu_op = ALU_SLT;  end
            OP_SLTIU: begin use_imm = 1'b1; reg_we = 1'b1; alu_op = ALU_SLTU; end
            OP_ANDI:  begin use_imm = 1'b1; zext_imm = 1'b1; reg_we = 1'b1; alu_op = ALU_AND; end
            OP_ORI:   begin use_imm = 1'b1; zext_imm = 1'b1; reg_we = 1'b1; alu_op = ALU_OR;  end
            OP_LUI:   begin reg_we = 1'b1; alu_op = ALU_LUI; end
            OP_LW:    begin use_imm = 1'b1; reg_we = 1'b1; mem_to_reg = 1'b1; end
            OP_SW:    begin use_imm = 1'b1; mem_we = 1'b1; end
            OP_BEQ:   if (rs_val == rt_val) pc_d = br_target;
            OP_BNE:   if (rs_val != rt_val) pc_d = br_target;
            OP_J:     pc_d = {6'd0, target};
            OP_JAL: begin
                pc_d    = {6'd0, target};
                link    = 1'b1;
                reg_we  = 1'b1;
                wr_addr = 5'd31;
            end
            default: ;
        endcase
    end

    assign alu_b = !use_imm ? rt_val : (zext_imm ? {16'd0, imm} : sext16(imm));

    // ALU: shifts take rt with shamt, lui builds from the raw immediate.
    always_comb begin
        alu_y = 32'd0;
        case (alu_op)
            ALU_ADD:  alu_y = rs_val + alu_b;
            ALU_SUB:  alu_y = rs_val - alu_b;
            ALU_AND:  alu_y = rs_val & alu_b;
            ALU_OR:   alu_y = rs_val | alu_b;
            ALU_NOR:  alu_y = ~(rs_val | alu_b);
            ALU_SLT:  alu_y = {31'd0, $signed(rs_val) < $signed(alu_b)};
            ALU_SLTU: alu_y = {31'd0, rs_val < alu_b};
            ALU_SLL:  alu_y = rt_val << shamt;
            ALU_SRL:  alu_y = rt_val >> shamt;
            ALU_LUI:  alu_y = {imm, 16'd0};
            default:  alu_y = 32'd0;
        endcase
    end

    assign wb_data = mem_to_reg ? mem_rdata : (link ? pc_plus1 : alu_y);

    // PC register; reset abandons whatever instruction is in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q <= 32'd0;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: tb/tb_mips_sc_core.sv
// Directed program bench for mips_sc_core: preloads state, single-steps the
// core and checks PC plus architectural state after each instruction.
module tb_mips_sc_core;

    logic clock;
    logic reset;
    int   checks;
    int   failures;

    mips_sc_core #(.IMEM_WORDS(256), .DMEM_WORDS(256)) dut (
        .clock (clock),
        .reset (reset)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one instruction and confirm where the PC landed.
    task automatic step(input logic [31:0] exp_pc);
        @(posedge clock);
        #1;
        check32("pc", dut.pc_q, exp_pc);
        $display("step pc=%0d expected=%0d", dut.pc_q, exp_pc);
    endtask

    logic [31:0] prog [0:27];

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        prog = '{
            32'hAC1D0001, // 0  sw  r29, 1(r0)
            32'h8C9D0008, // 1  lw  r29, 8(r4)
            32'h20640060, // 2  addi r4, r3, 0x60
            32'h00492820, // 3  add r5, r2, r9
            32'h30670063, // 4  andi r7, r3, 0x63
            32'h00E8482A, // 5  slt r9, r7, r8
            32'h28EA0003, // 6  slti r10, r7, 3
            32'h08000009, // 7  j 9
            32'h00430820, // 8  add r1, r2, r3 (skipped)
            32'h03DF602B, // 9  sltu r12, r30, r31
            32'h20210001, // 10 addi r1, r1, 1
            32'h1423FFFE, // 11 bne r1, r3, -2
            32'h00430020, // 12 add r0, r2, r3
            32'h001268C0, // 13 sll r13, r18, 3
            32'h001370C2, // 14 srl r14, r19, 3
            32'h00107824, // 15 and r15, r0, r16
            32'h00168027, // 16 nor r16, r0, r22
            32'h3C180F0F, // 17 lui r24, 0x0F0F
            32'h0C000014, // 18 jal 20
            32'h00000000, // 19 (skipped)
            32'hFFFFFFFF, // 20 unlisted opcode
            32'h00438822, // 21 sub r17, r2, r3
            32'hAC1801FF, // 22 sw r24, 0x1FF(r0) -> wraps to 255
            32'h10000001, // 23 beq r0, r0, +1
            32'h20010077, // 24 (skipped)
            32'h3419001B, // 25 ori r25, r0, 27
            32'h03200008, // 26 jr r25
            32'hAC180002  // 27 sw r24, 2(r0) (reset on this edge)
        };
        for (int i = 0; i < 256; i++) begin
            dut.Instruction_memory.instr_mem[i] = (i < 28) ? prog[i] : 32'd0;
            dut.Data_memory.data_mem[i] = i;
        end
        for (int i = 0; i < 32; i++) dut.Registers.registers[i] = i;
        dut.Registers.registers[30] = 32'hFFFF_FFFE;
        dut.Registers.registers[31] = 32'd12;

        step(32'd0);
        reset = 1'b0;

        step(32'd1);  check32("sw_mem1",   dut.Data_memory.data_mem[1], 32'd29);
        step(32'd2);  check32("lw_r29",    dut.Registers.registers[29], 32'd12);
        step(32'd3);  check32("addi_r4",   dut.Registers.registers[4], 32'h63);
        step(32'd4);  check32("add_r5",    dut.Registers.registers[5], 32'd11);
        step(32'd5);  check32("andi_r7",   dut.Registers.registers[7], 32'd3);
        step(32'd6);  check32("slt_r9",    dut.Registers.registers[9], 32'd1);
        step(32'd7);  check32("slti_r10",  dut.Registers.registers[10], 32'd0);
        step(32'd9);
        step(32'd10); check32("sltu_r12",  dut.Registers.registers[12], 32'd0);
                      check32("j_skip_r1", dut.Registers.registers[1], 32'd1);
        step(32'd11); check32("addi_r1",   dut.Registers.registers[1], 32'd2);
        step(32'd10);
        step(32'd11); check32("addi_r1b",  dut.Registers.registers[1], 32'd3);
        step(32'd12);
        step(32'd13); check32("r0_zero",   dut.Registers.registers[0], 32'd0);
        step(32'd14); check32("sll_r13",   dut.Registers.registers[13], 32'd144);
        step(32'd15); check32("srl_r14",   dut.Registers.registers[14], 32'd2);
        step(32'd16); check32("and_r15",   dut.Registers.registers[15], 32'd0);
        step(32'd17); check32("nor_r16",   dut.Registers.registers[16], 32'hFFFF_FFE9);
        step(32'd18); check32("lui_r24",   dut.Registers.registers[24], 32'h0F0F_0000);
        step(32'd20); check32("jal_r31",   dut.Registers.registers[31], 32'd19);
        step(32'd21); check32("nop_r31",   dut.Registers.registers[31], 32'd19);
        step(32'd22); check32("sub_r17",   dut.Registers.registers[17], 32'hFFFF_FFFF);
        step(32'd23); check32("sw_wrap",   dut.Data_memory.data_mem[255], 32'h0F0F_0000);
        step(32'd25);
        step(32'd26); check32("ori_r25",   dut.Registers.registers[25], 32'd27);
        step(32'd27);

        @(negedge clock);
        reset = 1'b1;
        step(32'd0);  check32("rst_nowr",  dut.Data_memory.data_mem[2], 32'd2);
        reset = 1'b0;
        step(32'd1);  check32("sw_again",  dut.Data_memory.data_mem[1], 32'd12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
